// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX/MEM pipeline register with stall hold, flush bubbles, sticky halt and saturating stall counter
module ex_mem_reg #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic              ex_reg_wr,
  input  logic [2:0]        ex_Rd,
  input  logic [2:0]        ex_wr_sel,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic              ex_set_result,
  input  logic [DATA_W-1:0] ex_lbi_result,
  input  logic [DATA_W-1:0] ex_slbi_result,
  input  logic [DATA_W-1:0] ex_st_data,
  input  logic              ex_mem_en,
  input  logic              ex_mem_wr,
  input  logic              ex_halt,
  output logic              ex_mem_valid,
  output logic              ex_mem_wr_en,
  output logic [2:0]        ex_mem_Rd,
  output logic [2:0]        ex_mem_wr_sel,
  output logic [DATA_W-1:0] ex_mem_alu_result,
  output logic [DATA_W-1:0] ex_mem_set_result,
  output logic [DATA_W-1:0] ex_mem_lbi_result,
  output logic [DATA_W-1:0] ex_mem_slbi_result,
  output logic [DATA_W-1:0] ex_mem_st_data,
  output logic              ex_mem_mem_en,
  output logic              ex_mem_mem_wr,
  output logic              ex_mem_halt,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt
);
  logic              valid_q, valid_d;
  logic              reg_wr_q, reg_wr_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_wr_q, mem_wr_d;
  logic              halt_q, halt_d;
  logic              halted_q, halted_d;
  logic [2:0]        rd_q, rd_d;
  logic [2:0]        wr_sel_q, wr_sel_d;
  logic              set_q, set_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] lbi_q, lbi_d;
  logic [DATA_W-1:0] slbi_q, slbi_d;
  logic [DATA_W-1:0] st_q, st_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              hold_data, load;
  // next state: stall holds everything, flush clears control only, otherwise load EX
  always_comb begin
    hold_data = stall | flush;
    load      = ~stall & ~flush;
    valid_d   = stall ? valid_q  : (flush ? 1'b0 : ex_valid);
    reg_wr_d  = stall ? reg_wr_q : (flush ? 1'b0 : ex_reg_wr);
    mem_en_d  = stall ? mem_en_q : (flush ? 1'b0 : ex_mem_en);
    mem_wr_d  = stall ? mem_wr_q : (flush ? 1'b0 : ex_mem_wr);
    halt_d    = stall ? halt_q   : (flush ? 1'b0 : ex_halt);
    rd_d      = hold_data ? rd_q     : ex_Rd;
    wr_sel_d  = hold_data ? wr_sel_q : ex_wr_sel;
    set_d     = hold_data ? set_q    : ex_set_result;
    alu_d     = hold_data ? alu_q    : ex_alu_result;
    lbi_d     = hold_data ? lbi_q    : ex_lbi_result;
    slbi_d    = hold_data ? slbi_q   : ex_slbi_result;
    st_d      = hold_data ? st_q     : ex_st_data;
    halted_d  = halted_q | (load & ex_valid & ex_halt);
    cnt_d     = (stall && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  // state registers, cleared asynchronously by active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= 1'b0;
      reg_wr_q <= 1'b0;
      mem_en_q <= 1'b0;
      mem_wr_q <= 1'b0;
      halt_q   <= 1'b0;
      halted_q <= 1'b0;
      rd_q     <= '0;
      wr_sel_q <= '0;
      set_q    <= 1'b0;
      alu_q    <= '0;
      lbi_q    <= '0;
      slbi_q   <= '0;
      st_q     <= '0;
      cnt_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      reg_wr_q <= reg_wr_d;
      mem_en_q <= mem_en_d;
      mem_wr_q <= mem_wr_d;
      halt_q   <= halt_d;
      halted_q <= halted_d;
      rd_q     <= rd_d;
      wr_sel_q <= wr_sel_d;
      set_q    <= set_d;
      alu_q    <= alu_d;
      lbi_q    <= lbi_d;
      slbi_q   <= slbi_d;
      st_q     <= st_d;
      cnt_q    <= cnt_d;
    end
  end
  // control outputs are gated by valid so a bubble never writes or forwards
  always_comb begin
    ex_mem_valid       = valid_q;
    ex_mem_wr_en       = reg_wr_q & valid_q;
    ex_mem_mem_en      = mem_en_q & valid_q;
    ex_mem_mem_wr      = mem_wr_q & valid_q;
    ex_mem_halt        = halt_q & valid_q;
    ex_mem_Rd          = rd_q;
    ex_mem_wr_sel      = wr_sel_q;
    ex_mem_alu_result  = alu_q;
    ex_mem_set_result  = {{(DATA_W-1){1'b0}}, set_q};
    ex_mem_lbi_result  = lbi_q;
    ex_mem_slbi_result = slbi_q;
    ex_mem_st_data     = st_q;
    halted             = halted_q;
    stall_cnt          = cnt_q;
  end
endmodule

// File: tb/tb_ex_mem_reg.sv
// tb_ex_mem_reg: directed scoreboard bench for the EX/MEM pipeline register
module tb_ex_mem_reg;
  logic        clk = 1'b0;
  logic        rst, stall, flush, ex_valid, ex_reg_wr, ex_set_result, ex_mem_en, ex_mem_wr, ex_halt;
  logic [2:0]  ex_Rd, ex_wr_sel;
  logic [15:0] ex_alu_result, ex_lbi_result, ex_slbi_result, ex_st_data;
  logic        o_valid, o_wr_en, o_mem_en, o_mem_wr, o_halt, o_halted;
  logic [2:0]  o_rd, o_sel;
  logic [15:0] o_alu, o_set, o_lbi, o_slbi, o_st, o_cnt;
  logic        s_valid, s_wr_en, s_mem_en, s_mem_wr, s_halt, s_halted;
  logic [2:0]  s_rd, s_sel;
  logic [15:0] s_alu, s_set, s_lbi, s_slbi, s_st;
  logic [3:0]  s_cnt;
  int n_total = 0;
  int n_fail = 0;

  typedef struct {
    logic [15:0] valid, wr_en, rd, sel, alu, setr, lbi, slbi, st, mem_en, mem_wr, halt, halted, cnt, scnt;
  } exp_t;
  exp_t sb[$];

  logic        m_valid, m_reg_wr, m_mem_en, m_mem_wr, m_halt, m_halted, m_set;
  logic [2:0]  m_rd, m_sel;
  logic [15:0] m_alu, m_lbi, m_slbi, m_st, m_cnt;
  logic [3:0]  m_scnt;

  always #5 clk = ~clk;

  ex_mem_reg #(.DATA_W(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .ex_valid(ex_valid), .ex_reg_wr(ex_reg_wr),
    .ex_Rd(ex_Rd), .ex_wr_sel(ex_wr_sel), .ex_alu_result(ex_alu_result), .ex_set_result(ex_set_result),
    .ex_lbi_result(ex_lbi_result), .ex_slbi_result(ex_slbi_result), .ex_st_data(ex_st_data),
    .ex_mem_en(ex_mem_en), .ex_mem_wr(ex_mem_wr), .ex_halt(ex_halt),
    .ex_mem_valid(o_valid), .ex_mem_wr_en(o_wr_en), .ex_mem_Rd(o_rd), .ex_mem_wr_sel(o_sel),
    .ex_mem_alu_result(o_alu), .ex_mem_set_result(o_set), .ex_mem_lbi_result(o_lbi),
    .ex_mem_slbi_result(o_slbi), .ex_mem_st_data(o_st), .ex_mem_mem_en(o_mem_en),
    .ex_mem_mem_wr(o_mem_wr), .ex_mem_halt(o_halt), .halted(o_halted), .stall_cnt(o_cnt)
  );

  ex_mem_reg #(.DATA_W(16), .CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .ex_valid(ex_valid), .ex_reg_wr(ex_reg_wr),
    .ex_Rd(ex_Rd), .ex_wr_sel(ex_wr_sel), .ex_alu_result(ex_alu_result), .ex_set_result(ex_set_result),
    .ex_lbi_result(ex_lbi_result), .ex_slbi_result(ex_slbi_result), .ex_st_data(ex_st_data),
    .ex_mem_en(ex_mem_en), .ex_mem_wr(ex_mem_wr), .ex_halt(ex_halt),
    .ex_mem_valid(s_valid), .ex_mem_wr_en(s_wr_en), .ex_mem_Rd(s_rd), .ex_mem_wr_sel(s_sel),
    .ex_mem_alu_result(s_alu), .ex_mem_set_result(s_set), .ex_mem_lbi_result(s_lbi),
    .ex_mem_slbi_result(s_slbi), .ex_mem_st_data(s_st), .ex_mem_mem_en(s_mem_en),
    .ex_mem_mem_wr(s_mem_wr), .ex_mem_halt(s_halt), .halted(s_halted), .stall_cnt(s_cnt)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    {m_valid, m_reg_wr, m_mem_en, m_mem_wr, m_halt, m_halted, m_set} = '0;
    m_rd = '0; m_sel = '0; m_alu = '0; m_lbi = '0; m_slbi = '0; m_st = '0; m_cnt = '0; m_scnt = '0;
  endtask

  function automatic exp_t cur_exp();
    exp_t e;
    e.valid = {15'd0, m_valid};
    e.wr_en = {15'd0, m_valid & m_reg_wr};
    e.rd = {13'd0, m_rd};
    e.sel = {13'd0, m_sel};
    e.alu = m_alu;
    e.setr = {15'd0, m_set};
    e.lbi = m_lbi;
    e.slbi = m_slbi;
    e.st = m_st;
    e.mem_en = {15'd0, m_valid & m_mem_en};
    e.mem_wr = {15'd0, m_valid & m_mem_wr};
    e.halt = {15'd0, m_valid & m_halt};
    e.halted = {15'd0, m_halted};
    e.cnt = m_cnt;
    e.scnt = {12'd0, m_scnt};
    return e;
  endfunction

  task automatic compare(input string tag, input exp_t e);
    chk({tag, ".valid"}, {15'd0, o_valid}, e.valid);
    chk({tag, ".wr_en"}, {15'd0, o_wr_en}, e.wr_en);
    chk({tag, ".rd"}, {13'd0, o_rd}, e.rd);
    chk({tag, ".wr_sel"}, {13'd0, o_sel}, e.sel);
    chk({tag, ".alu"}, o_alu, e.alu);
    chk({tag, ".set"}, o_set, e.setr);
    chk({tag, ".lbi"}, o_lbi, e.lbi);
    chk({tag, ".slbi"}, o_slbi, e.slbi);
    chk({tag, ".st"}, o_st, e.st);
    chk({tag, ".mem_en"}, {15'd0, o_mem_en}, e.mem_en);
    chk({tag, ".mem_wr"}, {15'd0, o_mem_wr}, e.mem_wr);
    chk({tag, ".halt"}, {15'd0, o_halt}, e.halt);
    chk({tag, ".halted"}, {15'd0, o_halted}, e.halted);
    chk({tag, ".stall_cnt"}, o_cnt, e.cnt);
    chk({tag, ".small_cnt"}, {12'd0, s_cnt}, e.scnt);
  endtask

  // advance the reference model for the current inputs, push its result, clock, pop and compare
  task automatic cyc(input string tag);
    exp_t e;
    if (stall) begin
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (m_scnt != 4'hF) m_scnt = m_scnt + 4'd1;
    end else if (flush) begin
      {m_valid, m_reg_wr, m_mem_en, m_mem_wr, m_halt} = '0;
    end else begin
      m_valid = ex_valid; m_reg_wr = ex_reg_wr; m_mem_en = ex_mem_en; m_mem_wr = ex_mem_wr;
      m_halt = ex_halt; m_rd = ex_Rd; m_sel = ex_wr_sel; m_set = ex_set_result;
      m_alu = ex_alu_result; m_lbi = ex_lbi_result; m_slbi = ex_slbi_result; m_st = ex_st_data;
      if (ex_valid && ex_halt) m_halted = 1'b1;
    end
    sb.push_back(cur_exp());
    @(posedge clk);
    #1;
    e = sb.pop_front();
    compare(tag, e);
  endtask

  task automatic set_ex(input logic v, input logic rw, input logic [2:0] rd, input logic [2:0] sel,
                        input logic [15:0] alu, input logic sr, input logic me, input logic mw,
                        input logic [15:0] st, input logic h);
    ex_valid = v; ex_reg_wr = rw; ex_Rd = rd; ex_wr_sel = sel; ex_alu_result = alu; ex_set_result = sr;
    ex_mem_en = me; ex_mem_wr = mw; ex_st_data = st; ex_halt = h;
    ex_lbi_result = alu ^ 16'h5A5A; ex_slbi_result = {alu[7:0], alu[15:8]};
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    set_ex(1, 1, 3'd7, 3'd5, 16'hFFFF, 1, 1, 1, 16'hFFFF, 1);
    model_reset();
    #3;
    compare("reset", cur_exp());
    #4 rst = 1'b1;
    set_ex(1, 1, 3'd3, 3'd0, 16'h1234, 0, 0, 0, 16'h0000, 0);
    cyc("load_alu");
    set_ex(1, 1, 3'd2, 3'd3, 16'h0000, 1, 0, 0, 16'h0000, 0);
    cyc("load_set");
    set_ex(1, 0, 3'd0, 3'd1, 16'h0040, 0, 1, 1, 16'hBEEF, 0);
    cyc("load_store");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_ex(1, 1, 3'(i + 4), 3'd4, 16'hA000 + 16'(i), 1, 0, 0, 16'h1111 * 16'(i + 1), 0);
      cyc($sformatf("stall%0d", i));
    end
    stall = 1'b0; flush = 1'b1;
    set_ex(1, 1, 3'd6, 3'd0, 16'hCAFE, 0, 1, 1, 16'h2222, 0);
    cyc("flush");
    flush = 1'b0;
    set_ex(1, 1, 3'd1, 3'd2, 16'h0F0F, 1, 1, 0, 16'h3333, 0);
    cyc("load_before_fs");
    stall = 1'b1; flush = 1'b1;
    set_ex(1, 1, 3'd5, 3'd5, 16'h7777, 0, 0, 0, 16'h4444, 0);
    cyc("flush_and_stall");
    stall = 1'b0; flush = 1'b0;
    set_ex(0, 1, 3'd4, 3'd7, 16'h8001, 0, 1, 1, 16'h5555, 1);
    cyc("invalid_sel7");
    flush = 1'b1;
    set_ex(1, 0, 3'd0, 3'd6, 16'h0002, 0, 0, 0, 16'h0000, 1);
    cyc("flush_halt");
    flush = 1'b0;
    cyc("valid_halt");
    set_ex(1, 1, 3'd2, 3'd0, 16'h00AA, 0, 0, 0, 16'h0000, 0);
    cyc("after_halt");
    stall = 1'b1;
    for (int i = 0; i < 18; i++) cyc($sformatf("sat%0d", i));
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    model_reset();
    compare("async_reset", cur_exp());
    #2 rst = 1'b1;
    stall = 1'b0;
    set_ex(1, 1, 3'd3, 3'd1, 16'h1234, 0, 1, 0, 16'h6666, 0);
    cyc("reload");
    if (sb.size() != 0) chk("sb_empty", 16'(sb.size()), 16'd0);
    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end
endmodule

// File: doc/ex_mem_reg.md
# ex_mem_reg

EX/MEM pipeline register of the five-stage WISC processor. It captures the execute-stage results and control for one instruction per cycle, and presents them to the memory stage and to the forwarding unit. It holds its contents on a downstream stall and inserts bubbles on flush. It also keeps a saturating count of stall cycles and a sticky halt flag for the testbench.

## Interface
- `DATA_W`, 16, datapath width
- `CNT_W`, 16, stall-counter width
- `clk`  in  1  system clock, all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `stall`  in  1  hold all contents (MEM stage busy)
- `flush`  in  1  load a bubble instead of the EX instruction
- `ex_valid`  in  1  EX holds a real instruction
- `ex_reg_wr`  in  1  instruction writes the register file
- `ex_Rd`  in  3  destination register
- `ex_wr_sel`  in  3  writeback select: 0 alu, 1 mem, 3 set, 4 lbi, 5 slbi
- `ex_alu_result`  in  DATA_W  ALU output, also the memory address
- `ex_set_result`  in  1  set-condition bit
- `ex_lbi_result`  in  DATA_W  sign-extended immediate
- `ex_slbi_result`  in  DATA_W  shifted-immediate result
- `ex_st_data`  in  DATA_W  store data (Rt after forwarding)
- `ex_mem_en`, `ex_mem_wr`  in  1 each  memory access / write
- `ex_halt`  in  1  HALT instruction
- `ex_mem_valid`  out  1  registered valid
- `ex_mem_wr_en`  out  1  `reg_wr & valid`, drives forwarding `mem_wr_en`
- `ex_mem_Rd`, `ex_mem_wr_sel`  out  3 each  registered
- `ex_mem_alu_result`, `ex_mem_lbi_result`, `ex_mem_slbi_result`, `ex_mem_st_data`  out  DATA_W  registered
- `ex_mem_set_result`  out  DATA_W  registered set bit, zero-extended to DATA_W
- `ex_mem_mem_en`, `ex_mem_mem_wr`  out  1 each  qualified by valid
- `ex_mem_halt`  out  1  qualified by valid
- `halted`  out  1  sticky: a valid halt has been captured
- `stall_cnt`  out  CNT_W  saturating count of stall cycles

## Operation
- Per-edge priority: reset > stall > flush > load.
- Reset (asynchronous, `rst`=0): all outputs 0, including `halted` and `stall_cnt`. Data registers clear.
- Stall: every register holds its value. `stall_cnt` increments and saturates at all-ones, with no wrap.
- Flush (no stall): valid←0. Control bits (`reg_wr`, `mem_en`, `mem_wr`, `halt`) clear. Data fields hold (don't-care, but deterministic).
- Load (no stall, no flush): all fields capture EX inputs, valid←`ex_valid`.
- Flush and stall both high: stall wins. The instruction already in EX/MEM is kept, and flush is lost for that cycle. The upstream hazard logic re-asserts flush until it is accepted.
- Qualification: the control outputs are ANDed with `ex_mem_valid`. An invalid slot never writes the register file or memory, and never forwards.
- `halted`: set on any edge where a valid halt is loaded. Cleared only by reset. After it is set, normal loads continue; freezing is the fetch stage's job.
- `ex_wr_sel` values 2, 6 and 7 are stored unchanged. This block does not check them.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear at outputs after edge N.
- Outputs are purely registered apart from the AND with valid. There is no combinational path from inputs to outputs.
- `rst` assertion clears outputs immediately, with no clock needed. Deassertion is synchronised externally. The first load happens at the first edge after deassertion.
- Reset mid-stall: the counter and contents clear, and stall is ignored while `rst`=0.

## Test plan
- Reset, then load `ex_valid=1, ex_reg_wr=1, ex_Rd=3, ex_alu_result=16'h1234` → next cycle `ex_mem_wr_en=1`, `ex_mem_Rd=3`, `ex_mem_alu_result=16'h1234`.
- Load `ex_set_result=1, ex_wr_sel=3` → `ex_mem_set_result=16'h0001`.
- Load a valid store, then `stall=1` for 3 cycles with changing EX inputs → outputs unchanged, `stall_cnt=3`.
- `flush=1` with `ex_valid=1, ex_reg_wr=1, ex_mem_wr=1` → `ex_mem_valid=0`, `ex_mem_wr_en=0`, `ex_mem_mem_wr=0`. `flush=1` together with `stall=1` → prior contents held.
- Preload `stall_cnt` to 16'hFFFE, stall 3 cycles → `stall_cnt=16'hFFFF`, no wrap.
- Valid `ex_halt=1` → `halted=1` and it stays 1. Pulse `rst=0` mid-cycle with no clock edge → all outputs 0 immediately.
